dg0045_fetch_sequencer: RTL
===========================

Name: dg0045_fetch_sequencer

Overview:
- Instruction-fetch controller that sits between the DG0045 CPU core and an external program ROM.
- Drives the CPU's PC half-select (PC_MUX) and samples the two 5-bit PC halves on the shared PC_HL pins.
- Reassembles the 10-bit address {PU,PL}, runs a req/ack read handshake with the ROM, and presents the fetched byte as the CPU instruction input, once per 8-clock machine cycle.
- On a late or missing ROM response it substitutes a fill opcode (NOP) so the core never stalls.

Parameters:
- DEADLINE_PH, 6, last phase (0..7) at which rom_ack is accepted; 3 <= DEADLINE_PH <= 6.
- FILL_OP, 8'h00, opcode presented on miss (NOP).

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  advance enable; when low, all state holds.
- pc_hl  in  5  PC half from core: PL[4:0] when pc_mux=0, {PU,PL[5]} when pc_mux=1.
- pc_mux  out  1  half-select to core.
- rom_req  out  1  read request, level.
- rom_addr  out  10  {PU[3:0],PL[5:0]}; stable while rom_req=1.
- rom_ack  in  1  one-cycle pulse; rom_data is valid in the same cycle.
- rom_data  in  8  ROM byte.
- cmd_out  out  8  instruction byte to the core's ui_in.
- cmd_strobe  out  1  one-cycle pulse when cmd_out updates.
- miss  out  1  one-cycle pulse when FILL_OP is substituted.
- phase  out  3  current machine-cycle phase.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - phase=0, FSM=S_LO.
  - pc_mux=0, rom_req=0, rom_addr=0.
  - cmd_out=FILL_OP, cmd_strobe=0, miss=0, internal data hold=FILL_OP.
- Reset wins over every other event. A request in flight is dropped: rom_req=0 on the first edge after rst.
- Phase counter:
  - 3-bit, increments by 1 per clk when ena=1 and wraps 7->0.
  - ena=0 freezes phase, FSM and all outputs. Pulse outputs are forced to 0 while ena=0.
  - A rom_ack arriving while ena=0 is ignored; the ROM must hold until ena returns.
- FSM (all transitions require ena=1):
  - S_LO, phase 0: pc_mux=0. At end of phase 1, capture pc_hl into lo[4:0], set pc_mux=1, go to S_HI.
  - S_HI, phase 2: at end of phase 2, capture pc_hl into hi[4:0] and load rom_addr={hi,lo}. Assert rom_req from phase 3. Go to S_REQ.
  - S_REQ, phases 3..DEADLINE_PH:
    - On rom_ack: latch rom_data into hold, drop rom_req next cycle, go to S_HOLD.
    - If phase==DEADLINE_PH with no ack: hold<=FILL_OP, set a miss flag, drop rom_req, go to S_HOLD.
    - Ack and deadline in the same cycle: ack wins, no miss.
  - S_HOLD:
    - At end of phase 7: cmd_out<=hold and cmd_strobe=1 for one cycle (visible in phase 0).
    - miss pulses in the same cycle as cmd_strobe if the miss flag is set; the flag then clears.
    - Set pc_mux=0 and go to S_LO.
- Latency: the address sampled in cycle N appears on cmd_out at phase 0 of cycle N+1, i.e. one machine cycle of fetch pipeline.
- rom_ack while rom_req=0 (late or stray) is ignored and does not alter hold.
- Address arithmetic: pure concatenation, no increment. Wrap-around of the PC is the core's responsibility.
- rom_addr holds its last value when rom_req=0.

Optional Feature:
- Macro: DG0045_FETCH_REUSE_EN.
- When defined:
  - A 10-bit last_addr register and a valid bit are added.
  - If {hi,lo}==last_addr, valid=1, and the previous fetch was not a miss: skip S_REQ, keep rom_req=0, and reuse hold.
  - This makes tight self-loops such as JMP-to-self ROM-silent.
  - rst clears valid.
- When undefined: every cycle issues a request, and the block has no last_addr hardware.

Decomposition:
- Package dg0045_fetch_pkg holds:
  - FSM state enum (S_LO, S_HI, S_REQ, S_HOLD).
  - Phase constants PH_LO_CAP=1, PH_HI_CAP=2, PH_REQ=3, PH_OUT=7.
  - NOP opcode constant.
- One natural sub-module: dg0045_phase_gen, the 3-bit enable-gated counter with sync reset, shared with future display/keyscan sequencers.

Test Plan:
- Basic fetch: pc_hl=5'h15 in phase 1, 5'h0A in phase 2; ack at phase 4 with rom_data=8'hC3 -> rom_addr=10'h155 from phase 3, rom_req falls at phase 5, cmd_out=8'hC3 with cmd_strobe at next phase 0, miss=0.
- Timeout: no ack, DEADLINE_PH=6 -> rom_req drops after phase 6, cmd_out=8'h00, miss and cmd_strobe pulse together.
- Ack on deadline phase 6 with rom_data=8'h5E -> cmd_out=8'h5E, no miss. Ack at phase 7 -> ignored, cmd_out=FILL_OP, miss=1.
- ena low for 5 clocks during S_REQ (phase 4) -> phase, rom_req=1 and rom_addr hold. Ack given after ena returns is accepted, and the output phase is delayed by exactly 5 clocks.
- rst asserted at phase 4 with rom_req=1 -> next edge: rom_req=0, phase=0, cmd_out=8'h00, pc_mux=0. The following cycle fetches normally.
- With DG0045_FETCH_REUSE_EN: two consecutive cycles at address 10'h3FF with the first acked data 8'h80 -> second cycle has no rom_req and cmd_out=8'h80. After a miss, the same address is re-requested.

Source files
------------

// File: rtl/dg0045_fetch_sequencer_pkg.sv
// rtl/dg0045_fetch_sequencer_pkg.sv - shared types and constants for the DG0045 fetch sequencer
// Purpose: FSM state encoding, machine-cycle phase landmarks and the NOP opcode.
// Ports: none (package).
package dg0045_fetch_pkg;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_REQ  = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [2:0] PH_LO_CAP = 3'd1;
  localparam logic [2:0] PH_HI_CAP = 3'd2;
  localparam logic [2:0] PH_REQ    = 3'd3;
  localparam logic [2:0] PH_OUT    = 3'd7;

  localparam logic [7:0] NOP_OP = 8'h00;

endpackage

// File: rtl/dg0045_fetch_sequencer_if.sv
// rtl/dg0045_fetch_sequencer_if.sv - program ROM read bus between fetch sequencer and ROM
// Purpose: level request with a stable address, answered by a one-cycle ack carrying data.
// Signals: rom_req (1), rom_addr (10) from sequencer; rom_ack (1), rom_data (8) from ROM.
// Modports: master = fetch sequencer, slave = ROM.
interface dg0045_fetch_sequencer_if;

  logic       rom_req;
  logic [9:0] rom_addr;
  logic       rom_ack;
  logic [7:0] rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );

endinterface

// File: rtl/dg0045_fetch_sequencer_phase_gen.sv
// rtl/dg0045_fetch_sequencer_phase_gen.sv - 3-bit machine-cycle phase counter
// Purpose: counts 0..7 and wraps, advancing only while i_ena is high.
// Ports: i_clk, i_rst (sync, active-high), i_ena (advance), o_phase[2:0].
module dg0045_phase_gen (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  output logic [2:0] o_phase
);

  logic [2:0] r_phase;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= 3'd0;
    end else if (i_ena) begin
      r_phase <= r_phase + 3'd1;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/dg0045_fetch_sequencer.sv
// rtl/dg0045_fetch_sequencer.sv - instruction fetch controller between DG0045 core and program ROM
// Purpose: samples the two PC halves over one 8-phase machine cycle, reads the ROM
//   and presents the byte to the core at phase 0 of the following cycle; a late or
//   missing ROM answer is replaced by FILL_OP.
// Ports: i_clk, i_rst (sync, active-high), i_ena (advance enable),
//   i_pc_hl[4:0] / o_pc_mux (PC half bus to core), rom (ROM bus, master),
//   o_cmd_out[7:0], o_cmd_strobe, o_miss (to core), o_phase[2:0].
// Option: DG0045_FETCH_REUSE_EN - skip the ROM read when the address repeats.
module dg0045_fetch_sequencer
  import dg0045_fetch_pkg::*;
#(
  parameter int         DEADLINE_PH = 6,
  parameter logic [7:0] FILL_OP     = NOP_OP
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_ena,
  input  logic [4:0]                      i_pc_hl,
  output logic                            o_pc_mux,
  dg0045_fetch_sequencer_if.master        rom,
  output logic [7:0]                      o_cmd_out,
  output logic                            o_cmd_strobe,
  output logic                            o_miss,
  output logic [2:0]                      o_phase
);

  localparam logic [2:0] DEADLINE = 3'(DEADLINE_PH);

  fetch_state_e r_state;
  fetch_state_e w_next_state;

  logic [2:0] w_phase;
  logic [4:0] r_lo;
  logic [9:0] r_addr;
  logic [7:0] r_hold;
  logic [7:0] r_cmd;
  logic       r_miss_flag;
  logic       r_strobe;
  logic       r_miss;

  logic       w_cap_lo;
  logic       w_cap_hi;
  logic       w_accept;
  logic       w_timeout;
  logic       w_emit;
  logic       w_reuse;
  logic       w_pc_mux;
  logic       w_rom_req;
  logic [9:0] w_fetch_addr;

  dg0045_phase_gen u_phase_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ena   (i_ena),
    .o_phase (w_phase)
  );

  // Upper half is on the pins during phase 2, lower half was latched in phase 1.
  assign w_fetch_addr = {i_pc_hl, r_lo};

`ifdef DG0045_FETCH_REUSE_EN
  logic [9:0] r_last_addr;
  logic       r_valid;

  // r_valid is only set by an acked fetch and cleared by a miss, so a hit
  // implies hold still carries real ROM data for this address.
  assign w_reuse = r_valid && (w_fetch_addr == r_last_addr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_addr <= 10'd0;
      r_valid     <= 1'b0;
    end else begin
      if (w_cap_hi && !w_reuse) r_last_addr <= w_fetch_addr;
      if (w_accept)             r_valid     <= 1'b1;
      if (w_timeout)            r_valid     <= 1'b0;
    end
  end
`else
  assign w_reuse = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LO;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_ena) begin
      case (r_state)
        S_LO:    if (w_phase == PH_LO_CAP) w_next_state = S_HI;
        S_HI:    if (w_phase == PH_HI_CAP) w_next_state = w_reuse ? S_HOLD : S_REQ;
        // Ack is checked first so an ack on the deadline phase still counts.
        S_REQ:   if (rom.rom_ack || (w_phase == DEADLINE)) w_next_state = S_HOLD;
        S_HOLD:  if (w_phase == PH_OUT) w_next_state = S_LO;
        default: w_next_state = S_LO;
      endcase
    end
  end

  // rom_req is exactly "waiting in S_REQ", so a stray ack outside it cannot be seen.
  always_comb begin
    w_cap_lo  = 1'b0;
    w_cap_hi  = 1'b0;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    w_emit    = 1'b0;
    w_pc_mux  = (r_state != S_LO);
    w_rom_req = (r_state == S_REQ);
    if (i_ena) begin
      case (r_state)
        S_LO:    w_cap_lo  = (w_phase == PH_LO_CAP);
        S_HI:    w_cap_hi  = (w_phase == PH_HI_CAP);
        S_REQ: begin
          w_accept  = rom.rom_ack;
          w_timeout = !rom.rom_ack && (w_phase == DEADLINE);
        end
        S_HOLD:  w_emit    = (w_phase == PH_OUT);
        default: ;
      endcase
    end
  end

  // Pulse registers only change while enabled so a pulse raised just before a
  // stall is still delivered once the stall ends.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lo        <= 5'd0;
      r_addr      <= 10'd0;
      r_hold      <= FILL_OP;
      r_cmd       <= FILL_OP;
      r_miss_flag <= 1'b0;
      r_strobe    <= 1'b0;
      r_miss      <= 1'b0;
    end else if (i_ena) begin
      r_strobe <= 1'b0;
      r_miss   <= 1'b0;
      if (w_cap_lo) r_lo   <= i_pc_hl;
      if (w_cap_hi) r_addr <= w_fetch_addr;
      if (w_accept) r_hold <= rom.rom_data;
      if (w_timeout) begin
        r_hold      <= FILL_OP;
        r_miss_flag <= 1'b1;
      end
      if (w_emit) begin
        r_cmd       <= r_hold;
        r_strobe    <= 1'b1;
        r_miss      <= r_miss_flag;
        r_miss_flag <= 1'b0;
      end
    end
  end

  assign rom.rom_req  = w_rom_req;
  assign rom.rom_addr = r_addr;
  assign o_pc_mux     = w_pc_mux;
  assign o_cmd_out    = r_cmd;
  assign o_cmd_strobe = r_strobe & i_ena;
  assign o_miss       = r_miss & i_ena;
  assign o_phase      = w_phase;

endmodule
